sequence_checker: RTL and testbench

//   Downstream consumer of the 8-byte sequence generator output. Qualifies each

---
 rtl/sequence_checker.sv | 104 ++++++++++
 tb/tb_sequence_checker.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/sequence_checker.sv
// sequence_checker: aligns a byte stream to the fixed 8-byte pattern, tracks lock and counts good sequences / byte errors
module sequence_checker #(
  parameter int LOCK_SEQS = 2,
  parameter int LOSS_ERRS = 3,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             locked,
  output logic [1:0]       sync_state,
  output logic [2:0]       exp_index,
  output logic             byte_err,
  output logic             seq_done,
  output logic [CNT_W-1:0] good_seq_cnt,
  output logic [CNT_W-1:0] err_cnt
);
  typedef enum logic [1:0] {HUNT = 2'd0, VERIFY = 2'd1, LOCKED = 2'd2} state_t;
  localparam int GW = $clog2(LOCK_SEQS + 1);
  localparam int MW = $clog2(LOSS_ERRS + 1);
  localparam logic [7:0] PAT [8] = '{8'hAF, 8'hBC, 8'hE2, 8'h78, 8'hFF, 8'hE2, 8'h0B, 8'h8D};
  state_t state, state_n;
  logic [2:0] idx_n;
  logic [GW-1:0] good_run, good_n;
  logic [MW-1:0] miss_run, miss_n;
  logic err_n, done_n, match, is_af;
  assign match      = in_data == PAT[exp_index];
  assign is_af      = in_data == 8'hAF;
  assign sync_state = state;
  assign locked     = state == LOCKED;
  always_comb begin
    state_n = state;
    idx_n   = exp_index;
    good_n  = good_run;
    miss_n  = miss_run;
    err_n   = 1'b0;
    done_n  = 1'b0;
    if (in_valid) begin
      case (state)
        HUNT: begin
          state_n = is_af ? VERIFY : HUNT;
          idx_n   = is_af ? 3'd1 : 3'd0;
        end
        VERIFY: begin
          if (match) begin
            idx_n = exp_index + 3'd1;
            if (exp_index == 3'd7) begin
              done_n = 1'b1;
              good_n = good_run + 1'b1;
              if (good_run == GW'(LOCK_SEQS - 1)) begin
                state_n = LOCKED;
                miss_n  = '0;
              end
            end
          end else begin
            err_n   = 1'b1;
            good_n  = '0;
            state_n = is_af ? VERIFY : HUNT;
            idx_n   = is_af ? 3'd1 : 3'd0;
          end
        end
        LOCKED: begin
          // flywheel: index keeps advancing regardless of match
          idx_n  = exp_index + 3'd1;
          done_n = match && exp_index == 3'd7;
          err_n  = !match;
          miss_n = match ? '0 : miss_run + 1'b1;
          if (!match && miss_run == MW'(LOSS_ERRS - 1)) begin
            state_n = HUNT;
            idx_n   = 3'd0;
            good_n  = '0;
            miss_n  = '0;
          end
        end
        default: begin
          state_n = HUNT;
          idx_n   = 3'd0;
        end
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= HUNT;
      exp_index    <= '0;
      good_run     <= '0;
      miss_run     <= '0;
      byte_err     <= 1'b0;
      seq_done     <= 1'b0;
      good_seq_cnt <= '0;
      err_cnt      <= '0;
    end else begin
      state     <= state_n;
      exp_index <= idx_n;
      good_run  <= good_n;
      miss_run  <= miss_n;
      byte_err  <= err_n;
      seq_done  <= done_n;
      if (done_n && !(&good_seq_cnt)) good_seq_cnt <= good_seq_cnt + 1'b1;
      if (err_n && !(&err_cnt)) err_cnt <= err_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_sequence_checker.sv
// tb_sequence_checker: directed and random byte streams checked against a behavioural model
module tb_sequence_checker;
  localparam int LOCK_SEQS = 2;
  localparam int LOSS_ERRS = 3;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic locked, byte_err, seq_done, locked2, byte_err2, seq_done2;
  logic [1:0] sync_state, sync_state2;
  logic [2:0] exp_index, exp_index2;
  logic [15:0] good_seq_cnt, err_cnt;
  logic [1:0] good_seq_cnt2, err_cnt2;
  logic [7:0] pat [8] = '{8'hAF, 8'hBC, 8'hE2, 8'h78, 8'hFF, 8'hE2, 8'h0B, 8'h8D};
  int errors = 0;
  int checks = 0;
  int m_state = 0, m_idx = 0, m_good = 0, m_miss = 0, m_be = 0, m_sd = 0, m_gc = 0, m_ec = 0;

  sequence_checker dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .locked(locked), .sync_state(sync_state), .exp_index(exp_index),
    .byte_err(byte_err), .seq_done(seq_done),
    .good_seq_cnt(good_seq_cnt), .err_cnt(err_cnt));

  sequence_checker #(.CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .locked(locked2), .sync_state(sync_state2), .exp_index(exp_index2),
    .byte_err(byte_err2), .seq_done(seq_done2),
    .good_seq_cnt(good_seq_cnt2), .err_cnt(err_cnt2));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int lim);
    return v > lim ? lim : v;
  endfunction

  task automatic model_step(input bit r, input bit v, input logic [7:0] d);
    m_be = 0;
    m_sd = 0;
    if (r) begin
      {m_state, m_idx, m_good, m_miss, m_gc, m_ec} = '0;
      return;
    end
    if (!v) return;
    if (m_state == 0) begin
      if (d == 8'hAF) begin m_state = 1; m_idx = 1; end
    end else if (m_state == 1) begin
      if (d == pat[m_idx]) begin
        if (m_idx == 7) begin
          m_sd = 1; m_gc++; m_good++;
          if (m_good >= LOCK_SEQS) begin m_state = 2; m_miss = 0; end
        end
        m_idx = (m_idx + 1) % 8;
      end else begin
        m_be = 1; m_ec++; m_good = 0;
        if (d == 8'hAF) m_idx = 1;
        else begin m_state = 0; m_idx = 0; end
      end
    end else begin
      if (d == pat[m_idx]) begin
        m_miss = 0;
        if (m_idx == 7) begin m_sd = 1; m_gc++; end
      end else begin
        m_be = 1; m_ec++; m_miss++;
      end
      m_idx = (m_idx + 1) % 8;
      if (m_miss >= LOSS_ERRS) begin m_state = 0; m_idx = 0; m_good = 0; m_miss = 0; end
    end
  endtask

  task automatic step(input bit r, input bit v, input logic [7:0] d);
    @(negedge clk);
    reset = r;
    in_valid = v;
    in_data = d;
    @(posedge clk);
    model_step(r, v, d);
    #1;
    check("locked", 32'(locked), 32'(m_state == 2));
    check("sync_state", 32'(sync_state), m_state);
    check("exp_index", 32'(exp_index), m_idx);
    check("byte_err", 32'(byte_err), m_be);
    check("seq_done", 32'(seq_done), m_sd);
    check("good_seq_cnt", 32'(good_seq_cnt), sat(m_gc, 65535));
    check("err_cnt", 32'(err_cnt), sat(m_ec, 65535));
    check("good_seq_cnt_w2", 32'(good_seq_cnt2), sat(m_gc, 3));
    check("err_cnt_w2", 32'(err_cnt2), sat(m_ec, 3));
  endtask

  task automatic send_pat(input int first, input int n, input bit gaps);
    for (int i = first; i < first + n; i++) begin
      if (gaps) step(1'b0, 1'b0, 8'($urandom));
      step(1'b0, 1'b1, pat[i % 8]);
    end
  endtask

  initial begin
    int ptr;
    step(1'b1, 1'b0, 8'h00);
    check("reset_cnt", 32'(good_seq_cnt), 0);
    send_pat(0, 16, 1'b0);
    check("t1_locked", 32'(locked), 1);
    check("t1_good", 32'(good_seq_cnt), 2);
    check("t1_err", 32'(err_cnt), 0);

    step(1'b1, 1'b0, 8'h00);
    send_pat(0, 16, 1'b1);
    check("t2_locked", 32'(locked), 1);
    check("t2_good", 32'(good_seq_cnt), 2);

    step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b1, 8'h12);
    step(1'b0, 1'b1, 8'hE2);
    step(1'b0, 1'b1, 8'hBC);
    check("t3_hunt", 32'(sync_state), 0);
    step(1'b0, 1'b1, 8'hAF);
    check("t3_idx", 32'(exp_index), 1);
    check("t3_err", 32'(err_cnt), 0);
    send_pat(1, 7, 1'b0);

    step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'hAF);
    step(1'b0, 1'b1, 8'hBC);
    step(1'b0, 1'b1, 8'h00);
    check("t4_err", 32'(err_cnt), 1);
    check("t4_hunt", 32'(sync_state), 0);
    step(1'b0, 1'b1, 8'hAF);
    step(1'b0, 1'b1, 8'hBC);
    step(1'b0, 1'b1, 8'hAF);
    check("t4_rearm_state", 32'(sync_state), 1);
    check("t4_rearm_idx", 32'(exp_index), 1);

    step(1'b1, 1'b0, 8'h00);
    send_pat(0, 16, 1'b0);
    step(1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b1, 8'h00);
    send_pat(2, 6, 1'b0);
    check("t5_still_locked", 32'(locked), 1);
    check("t5_err", 32'(err_cnt), 2);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'h00);
    check("t5_lost", 32'(locked), 0);
    check("t5_state", 32'(sync_state), 0);

    step(1'b1, 1'b0, 8'h00);
    send_pat(0, 16, 1'b0);
    step(1'b1, 1'b1, 8'hAF);
    check("t6_rst_locked", 32'(locked), 0);
    check("t6_rst_good", 32'(good_seq_cnt), 0);
    send_pat(0, 40, 1'b0);
    check("t6_sat_w2", 32'(good_seq_cnt2), 3);
    check("t6_good_w16", 32'(good_seq_cnt), 5);

    ptr = 0;
    for (int n = 0; n < 3000; n++) begin
      int r;
      bit v;
      logic [7:0] d;
      r = $urandom_range(0, 199);
      v = $urandom_range(0, 3) != 0;
      if (r < 2) begin
        step(1'b1, v, 8'($urandom));
        ptr = 0;
      end else begin
        r = $urandom_range(0, 99);
        d = r < 90 ? pat[ptr % 8] : (r < 94 ? 8'hAF : 8'($urandom));
        if (v && r < 90) ptr++;
        step(1'b0, v, d);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
